fifo_reader: RTL and testbench

Read-side master for the team's synchronous `fifo` (enq/deq, one-cycle read latency). Waits until the FIFO holds a full burst, or until a flush is requested, then pops the burst with `deq`. Presents the words on a valid/ready stream, with `m_last` marking each burst boundary. It sits between the buffering FIFO and any downstream consumer that applies backpressure.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_skid_buf.sv | 41 ++++
 rtl/fifo_reader.sv | 76 +++++++
 tb/tb_fifo_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and read-side FSM states for the fifo stream blocks.
package fifo_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_BITS = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry in-order valid/ready buffer carrying a last flag per word.
module fifo_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         last_in,
  output logic [W-1:0] dout,
  output logic         last_out,
  output logic         valid,
  input  logic         ready,
  output logic [1:0]   occ
);
  logic [W:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       pop;
  assign valid = occ_q != 2'd0;
  assign pop = valid && ready;
  assign occ = occ_q;
  assign {last_out, dout} = head_q;
  // head only moves on a pop or when an empty/draining buffer receives a word
  always_comb begin
    head_d = (pop && occ_q == 2'd2) ? tail_q :
             (push && (occ_q == 2'd0 || (pop && occ_q == 2'd1))) ? {last_in, din} : head_q;
    tail_d = (push && ((occ_q == 2'd1 && !pop) || (occ_q == 2'd2 && pop))) ? {last_in, din} : tail_q;
    occ_d = occ_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops bursts from a one-cycle-latency FIFO onto a valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_BITS = fifo_pkg::ADDR_BITS,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [ADDR_BITS-1:0]  fifo_usedw,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_deq,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);
  localparam int CW = $clog2(BURST_LEN + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] blen_q, blen_d, issued_q, issued_d, sent_q, sent_d;
  logic          inflight_q;
  logic [1:0]    occ;
  logic          start, go, pop, credit, last_in;
  assign start = en && (fifo_usedw >= ADDR_BITS'(BURST_LEN) || (flush && !fifo_empty));
  assign go = state_q == IDLE && start;
  assign pop = m_valid && m_ready;
  // buffered plus in-flight words may never exceed the two buffer slots
  assign credit = 3'(occ) + 3'(inflight_q) < 3'd2 + 3'(pop);
  // the word being pushed has index sent + occ within the burst
  assign last_in = (CW+2)'(sent_q) + (CW+2)'(occ) == (CW+2)'(blen_q) - (CW+2)'(1);
  always_ff @(posedge clk) state_q <= !rst_n ? IDLE : state_d;
  always_comb begin
    state_d = go ? ISSUE :
              (state_q == ISSUE && fifo_deq && issued_q == blen_q - CW'(1)) ? DRAIN :
              (state_q == DRAIN && pop && m_last) ? IDLE : state_q;
  end
  always_comb begin
    fifo_deq = rst_n && state_q == ISSUE && issued_q < blen_q && !fifo_empty && credit;
    busy = state_q != IDLE;
  end
  always_comb begin
    blen_d = go ? (fifo_usedw >= ADDR_BITS'(BURST_LEN) ? CW'(BURST_LEN) : CW'(fifo_usedw)) : blen_q;
    issued_d = go ? '0 : issued_q + CW'(fifo_deq);
    sent_d = go ? '0 : sent_q + CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blen_q <= '0;
      issued_q <= '0;
      sent_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      blen_q <= blen_d;
      issued_q <= issued_d;
      sent_q <= sent_d;
      inflight_q <= fifo_deq;
    end
  end
  fifo_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight_q),
    .din(fifo_data_out),
    .last_in(last_in),
    .dout(m_data),
    .last_out(m_last),
    .valid(m_valid),
    .ready(m_ready),
    .occ(occ)
  );
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scenario tasks against a queue-based FIFO and burst/stream reference model.
module tb_fifo_reader;
  localparam int DW = 32, AB = 10, BL = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
  logic [AB-1:0] fifo_usedw = '0;
  logic [DW-1:0] fifo_data_out = '0;
  logic fifo_deq, m_valid, m_last, busy;
  logic [DW-1:0] m_data;
  int checks = 0, failures = 0;
  typedef struct {logic deq, valid, ready, last, busy; logic [DW-1:0] data;} rec_t;
  rec_t log_q[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] got_d[$];
  logic got_l[$];

  fifo_reader #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_usedw(fifo_usedw), .fifo_data_out(fifo_data_out), .fifo_deq(fifo_deq),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // sample mid-cycle, then apply the FIFO's pop one step after the edge
  task automatic step();
    rec_t r;
    @(negedge clk);
    r.deq = fifo_deq; r.valid = m_valid; r.ready = m_ready;
    r.last = m_last; r.busy = busy; r.data = m_data;
    log_q.push_back(r);
    if (rst_n && r.valid && r.ready) begin
      got_d.push_back(r.data);
      got_l.push_back(r.last);
    end
    @(posedge clk);
    #1;
    if (r.deq && q.size() > 0) fifo_data_out = q.pop_front();
    fifo_usedw = AB'(q.size());
    fifo_empty = q.size() == 0;
  endtask

  task automatic preload(input logic [DW-1:0] w);
    q.push_back(w);
    fifo_usedw = AB'(q.size());
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete(); got_d.delete(); got_l.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    q.delete(); fifo_usedw = '0; fifo_empty = 1'b1;
    step(); step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  function automatic int count_deq();
    int n = 0;
    foreach (log_q[i]) n += int'(log_q[i].deq);
    return n;
  endfunction

  task automatic test_reset();
    rec_t r;
    rst_n = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) preload(DW'(i + 1));
    repeat (3) step();
    r = log_q[log_q.size()-1];
    checks++; if (r.deq !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", r.deq); end
    checks++; if (r.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", r.valid); end
    checks++; if (r.last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", r.last); end
    checks++; if (r.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", r.busy); end
    checks++; if (r.data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", r.data); end
    checks++; if (count_deq() != 0) begin failures++; $display("FAIL reset_no_deq got=%0d exp=0", count_deq()); end
  endtask

  task automatic test_full_burst();
    logic [DW-1:0] w[4];
    logic [7:0] pat = '0;
    int fv = -1, h = -1;
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset();
    foreach (w[i]) preload(w[i]);
    en = 1'b1; m_ready = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 8; i++) pat[i] = log_q[i].deq;
    foreach (log_q[i]) begin
      if (fv < 0 && log_q[i].valid) fv = i;
      if (log_q[i].valid && log_q[i].ready && log_q[i].last) h = i;
    end
    checks++; if (pat !== 8'b0001_1110) begin failures++; $display("FAIL full_deq_pattern got=%b exp=00011110", pat); end
    checks++; if (fv != 3) begin failures++; $display("FAIL full_valid_latency got=%0d exp=3", fv); end
    checks++; if (got_d.size() != 4) begin failures++; $display("FAIL full_count got=%0d exp=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== w[i] || got_l[i] !== (i == 3)) begin
        failures++; $display("FAIL full_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], w[i], i == 3);
      end
    end
    checks++; if (log_q[0].busy !== 1'b0 || log_q[1].busy !== 1'b1) begin
      failures++; $display("FAIL full_busy_rise got=%b%b exp=01", log_q[0].busy, log_q[1].busy);
    end
    checks++; if (h != 6 || log_q[6].busy !== 1'b1 || log_q[7].busy !== 1'b0) begin
      failures++; $display("FAIL full_busy_fall got=h%0d,%b%b exp=h6,10", h, log_q[6].busy, log_q[7].busy);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] w[3];
    do_reset();
    foreach (w[i]) begin w[i] = $urandom; preload(w[i]); end
    en = 1'b1; m_ready = 1'b1;
    repeat (20) step();
    checks++; if (count_deq() != 0) begin failures++; $display("FAIL below_thresh_deq got=%0d exp=0", count_deq()); end
    clear_logs();
    flush = 1'b1; step(); flush = 1'b0;
    repeat (12) step();
    checks++; if (count_deq() != 3) begin failures++; $display("FAIL flush_deq got=%0d exp=3", count_deq()); end
    checks++; if (got_d.size() != 3) begin failures++; $display("FAIL flush_count got=%0d exp=3", got_d.size()); end
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== w[i] || got_l[i] !== (i == 2)) begin
        failures++; $display("FAIL flush_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], w[i], i == 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[4];
    int nv = 0, bad = 0;
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset();
    foreach (w[i]) preload(w[i]);
    en = 1'b1; m_ready = 1'b0;
    repeat (10) step();
    foreach (log_q[i]) if (log_q[i].valid) begin nv++; if (log_q[i].data !== 32'h11) bad++; end
    checks++; if (count_deq() != 2) begin failures++; $display("FAIL bp_deq got=%0d exp=2", count_deq()); end
    checks++; if (nv != 7 || bad != 0) begin failures++; $display("FAIL bp_hold got=valid%0d,bad%0d exp=valid7,bad0", nv, bad); end
    m_ready = 1'b1;
    repeat (12) step();
    checks++; if (count_deq() != 4) begin failures++; $display("FAIL bp_total_deq got=%0d exp=4", count_deq()); end
    checks++; if (got_d.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== w[i] || got_l[i] !== (i == 3)) begin
        failures++; $display("FAIL bp_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], w[i], i == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[8];
    int f = -1, l = -1, gap = 0;
    do_reset();
    foreach (w[i]) begin w[i] = $urandom; preload(w[i]); end
    en = 1'b1; m_ready = 1'b1;
    repeat (30) step();
    foreach (log_q[i]) if (log_q[i].busy) begin if (f < 0) f = i; l = i; end
    for (int i = f + 1; i < l; i++) if (!log_q[i].busy) gap++;
    checks++; if (gap != 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=1", gap); end
    checks++; if (count_deq() != 8) begin failures++; $display("FAIL b2b_deq got=%0d exp=8", count_deq()); end
    checks++; if (got_d.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== w[i] || got_l[i] !== (i % BL == BL - 1)) begin
        failures++; $display("FAIL b2b_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], w[i], i % BL == BL - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rem[$];
    rec_t r;
    int k = 0, en_n;
    do_reset();
    for (int i = 0; i < 8; i++) preload($urandom);
    en = 1'b1; m_ready = 1'b1;
    while (count_deq() < 2 && k < 10) begin step(); k++; end
    checks++; if (count_deq() < 2) begin failures++; $display("FAIL rstmid_wait got=%0d exp=2", count_deq()); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    rem = q;
    clear_logs();
    step();
    r = log_q[0];
    checks++; if ({r.deq, r.valid, r.last, r.busy} !== 4'b0 || r.data !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%b%b%b%b,%h exp=0000,0", r.deq, r.valid, r.last, r.busy, r.data);
    end
    repeat (20) step();
    en_n = rem.size() >= BL ? BL : 0;
    checks++; if (got_d.size() != en_n) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", got_d.size(), en_n); end
    for (int i = 0; i < en_n && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== rem[i] || got_l[i] !== (i == en_n - 1)) begin
        failures++; $display("FAIL rstmid_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], rem[i], i == en_n - 1);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [DW-1:0] w[8];
    int k = 0;
    do_reset();
    foreach (w[i]) begin w[i] = $urandom; preload(w[i]); end
    en = 1'b1; m_ready = 1'b1;
    while (count_deq() < 1 && k < 10) begin step(); k++; end
    en = 1'b0;
    repeat (25) step();
    checks++; if (count_deq() != 4) begin failures++; $display("FAIL endrop_deq got=%0d exp=4", count_deq()); end
    checks++; if (q.size() != 4 || busy !== 1'b0) begin failures++; $display("FAIL endrop_idle got=%0d,%b exp=4,0", q.size(), busy); end
    checks++; if (got_d.size() != 4) begin failures++; $display("FAIL endrop_count got=%0d exp=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== w[i] || got_l[i] !== (i == 3)) begin
        failures++; $display("FAIL endrop_word%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], w[i], i == 3);
      end
    end
  endtask

  // with flush held, the FIFO contents drain as bursts of min(remaining, BL)
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [DW-1:0] exp_d[$];
      logic exp_l[$];
      int n, rem, k = 0, out = 0, max_out = 0, unstable = 0;
      do_reset();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin exp_d.push_back($urandom); preload(exp_d[i]); end
      rem = n;
      while (rem > 0) begin
        int b = rem < BL ? rem : BL;
        for (int j = 0; j < b; j++) exp_l.push_back(j == b - 1);
        rem -= b;
      end
      en = 1'b1; flush = 1'b1;
      while (k < 300 && !(got_d.size() >= n && !log_q[log_q.size()-1].busy)) begin
        m_ready = $urandom_range(0, 3) != 0;
        step(); k++;
      end
      m_ready = 1'b1;
      repeat (5) step();
      foreach (log_q[i]) begin
        out += int'(log_q[i].deq) - int'(log_q[i].valid && log_q[i].ready);
        if (out > max_out) max_out = out;
        if (i > 0 && log_q[i-1].valid && !log_q[i-1].ready &&
            (!log_q[i].valid || log_q[i].data !== log_q[i-1].data || log_q[i].last !== log_q[i-1].last)) unstable++;
      end
      checks++; if (got_d.size() != n) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_d.size(), n); end
      checks++; if (max_out > 2) begin failures++; $display("FAIL rand%0d_credit got=%0d exp<=2", it, max_out); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL rand%0d_stable got=%0d exp=0", it, unstable); end
      for (int i = 0; i < n && i < got_d.size(); i++) begin
        checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          failures++; $display("FAIL rand%0d_word%0d got=%h/%b exp=%h/%b", it, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_en_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
